mul_sched: RTL and testbench
============================

# mul_sched

Two-requester scheduler for the shared 16x16 shift-add sequential multiplier. Arbitrates round-robin between two clients and launches one multiply at a time, pulsing the multiplier's LOAD and watching its Wait/Ready status. Captures the 32-bit product, returns it to the winning client with a one-cycle acknowledge, and short-circuits zero operands without occupying the datapath.

## Interface

Parameters:
- none; widths are fixed at 16-bit operands and a 32-bit product.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ0, REQ1  in  1  request from client 0 or 1; hold high until the matching ACK.
- A0, B0, A1, B1  in  16  operands; hold stable while the matching REQ is high.
- ACK0, ACK1  out  1  one-cycle pulse; RESULT is valid in the same cycle.
- RESULT  out  32  last product; holds its value until the next ACK.
- BUSY  out  1  high in every state except IDLE.
- MUL_LOAD  out  1  load strobe to the multiplier.
- MUL_A, MUL_B  out  16  operands to the multiplier; registered, stable from LOAD through RUN.
- MUL_WAIT  in  1  multiplier busy flag: its B register is nonzero.
- MUL_READY  in  1  multiplier final-step flag: its B register equals 1.
- MUL_RESULT  in  32  multiplier product output.

## Operation

- States: IDLE, LOAD, RUN, DONE.
- IDLE, arbitration:
  - A single request wins.
  - When both are high, the requester selected by the priority pointer wins.
  - The pointer moves to the other requester after every grant, including zero short-circuits.
- IDLE, on a grant:
  - Latch the requester ID and the operands.
  - If either operand is 0, set the product register to 0 and go to DONE. MUL_LOAD never asserts in this case.
  - Otherwise go to LOAD.
- LOAD: MUL_LOAD = 1 for exactly one cycle, then go to RUN.
- RUN:
  - Sample MUL_READY each cycle.
  - When MUL_READY = 1, capture MUL_RESULT into RESULT and go to DONE.
  - If MUL_WAIT = 0 with MUL_READY = 0 (protocol violation), go to DONE with RESULT = 0xFFFFFFFF.
- DONE: assert the ACK of the latched requester, then return to IDLE.
- Arithmetic:
  - Unsigned: RESULT = A × B, 32 bits, no overflow possible.
  - MUL_A/MUL_B may be swapped (see Configuration); the product is unchanged.
- After an ACK, a requester must drop REQ before the next rising edge. A REQ still high in the following IDLE cycle is a new request.
- Reset values: state IDLE, pointer = client 0, ACK0 = ACK1 = 0, MUL_LOAD = 0, BUSY = 0, RESULT = 0, MUL_A = MUL_B = 0.
- Reset mid-operation: abort immediately. No ACK is issued and the pending request is dropped. The multiplier shares RESET, so it clears too.

## Timing

- Let k = index of the most-significant set bit of the operand driven on MUL_B (0..15).
- Nonzero multiply: ACK is high in cycle c+k+3, where c is the IDLE cycle that granted. This breaks down as:
  - 1 cycle IDLE→LOAD
  - 1 cycle LOAD→RUN
  - k+1 RUN cycles
  - DONE
- Zero operand: ACK in cycle c+1.
- Back-to-back throughput: the next grant can occur in the cycle after DONE (the IDLE cycle).
- A REQ that rises while BUSY is high waits; no requests are queued beyond the two REQ lines.
- ACK0 and ACK1 are never high in the same cycle.

## Configuration

- MUL_SCHED_SWAP_EN defined:
  - In IDLE, if latched A < latched B (unsigned), drive MUL_A = B and MUL_B = A.
  - The smaller operand then sets the iteration count; k = msb(min(A, B)).
- MUL_SCHED_SWAP_EN undefined: MUL_A = A and MUL_B = B always; k = msb(B).

## Test plan

- Reset: hold RESET 2 cycles with REQ0 = 1 → all outputs 0, no ACK. Release → grant to client 0 the next cycle.
- Single multiply: REQ0, A0 = 3, B0 = 5 → ACK0 in cycle c+5, RESULT = 0x0000000F. MUL_LOAD pulses exactly once.
- Contention: REQ0 and REQ1 together, A0 = 7, B0 = 2, A1 = 0xFFFF, B1 = 0xFFFF → ACK0 first with RESULT = 14. Then ACK1 with 0xFFFE0001, 18 cycles after its grant. A second contention round serves client 1 first.
- Zero short-circuit: A1 = 0x1234, B1 = 0 → ACK1 at c+1, RESULT = 0, MUL_LOAD never asserted.
- Reset mid-RUN: start A0 = 9, B0 = 0x8000, assert RESET in the 4th RUN cycle → no ACK, state IDLE, RESULT = 0.
- Swap: A0 = 0x0002, B0 = 0x8000 → RESULT = 0x00010000. ACK at c+4 with MUL_SCHED_SWAP_EN, at c+18 without.

Source files
------------

// File: rtl/mul_sched_if.sv
// Bus bundle between mul_sched, its two clients and the shared sequential multiplier.
//   client side : req0/req1, a0/b0/a1/b1 in; ack0/ack1, result, busy out
//   mul side    : mul_load, mul_a, mul_b out; mul_wait, mul_ready, mul_result in
// slave  = the scheduler's view, master = clients plus multiplier.
interface mul_sched_if;
    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;

    logic              req0;
    logic              req1;
    logic [OP_W-1:0]   a0;
    logic [OP_W-1:0]   b0;
    logic [OP_W-1:0]   a1;
    logic [OP_W-1:0]   b1;
    logic              ack0;
    logic              ack1;
    logic [PROD_W-1:0] result;
    logic              busy;
    logic              mul_load;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic              mul_wait;
    logic              mul_ready;
    logic [PROD_W-1:0] mul_result;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_wait, mul_ready, mul_result,
        output ack0, ack1, result, busy, mul_load, mul_a, mul_b
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, mul_wait, mul_ready, mul_result,
        input  ack0, ack1, result, busy, mul_load, mul_a, mul_b
    );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler for two clients sharing one 16x16 shift-add multiplier.
// Launches one multiply at a time (LOAD pulse, then waits for mul_ready), returns
// the product with a one-cycle ack to the winner, and answers zero operands directly.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : mul_sched_if.slave (client request/ack/result/busy, multiplier load/operands/status)
// Optional feature: define MUL_SCHED_SWAP_EN to put the smaller operand on mul_b,
// which bounds the multiplier iteration count by the smaller operand.
module mul_sched (
    input  logic       clk,
    input  logic       reset,
    mul_sched_if.slave bus
);
    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic            ptr;      // client favoured when both request
    logic            owner;    // client being served
    logic            grant_c;
    logic            winner_c;
    logic            swap_c;
    logic [OP_W-1:0] win_a_c;
    logic [OP_W-1:0] win_b_c;

    // Arbitration and operand selection for the current IDLE cycle
    always_comb begin
        winner_c = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner_c = ptr;
        end else if (bus.req1) begin
            winner_c = 1'b1;
        end
        grant_c = bus.req0 | bus.req1;
        win_a_c = winner_c ? bus.a1 : bus.a0;
        win_b_c = winner_c ? bus.b1 : bus.b0;
`ifdef MUL_SCHED_SWAP_EN
        swap_c  = (win_a_c < win_b_c);
`else
        swap_c  = 1'b0;
`endif
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            owner        <= 1'b0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.mul_load <= 1'b0;
            bus.result   <= '0;
            bus.mul_a    <= '0;
            bus.mul_b    <= '0;
        end else begin
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.mul_load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_c) begin
                        owner    <= winner_c;
                        ptr      <= ~winner_c;
                        bus.busy <= 1'b1;
                        if ((win_a_c == '0) || (win_b_c == '0)) begin
                            // Zero product: skip the datapath entirely
                            bus.result <= '0;
                            bus.ack0   <= ~winner_c;
                            bus.ack1   <= winner_c;
                            state      <= DONE;
                        end else begin
                            bus.mul_a    <= swap_c ? win_b_c : win_a_c;
                            bus.mul_b    <= swap_c ? win_a_c : win_b_c;
                            bus.mul_load <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (bus.mul_ready) begin
                        bus.result <= bus.mul_result;
                        bus.ack0   <= ~owner;
                        bus.ack1   <= owner;
                        state      <= DONE;
                    end else if (!bus.mul_wait) begin
                        // Multiplier went idle without a final step: flag with all ones
                        bus.result <= {PROD_W{1'b1}};
                        bus.ack0   <= ~owner;
                        bus.ack1   <= owner;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: shift-add multiplier model, per-scenario tasks, scoreboard queue.
module tb_mul_sched;
    logic clk;
    logic reset;
    logic viol;

    mul_sched_if bus ();

    mul_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-add multiplier model; viol forces a status protocol violation
    logic [31:0] ma;
    logic [15:0] mb;
    logic [31:0] mp;
    always @(posedge clk) begin
        if (reset) begin
            ma <= '0; mb <= '0; mp <= '0;
        end else if (bus.mul_load) begin
            ma <= {16'd0, bus.mul_a}; mb <= bus.mul_b; mp <= '0;
        end else if (mb != 16'd0) begin
            if (mb[0]) mp <= mp + ma;
            ma <= ma << 1;
            mb <= mb >> 1;
        end
    end
    assign bus.mul_wait   = viol ? 1'b0 : (mb != 16'd0);
    assign bus.mul_ready  = viol ? 1'b0 : (mb == 16'd1);
    assign bus.mul_result = mp + (mb[0] ? ma : 32'd0);

    typedef struct {
        logic        id;
        logic [31:0] prod;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   passes   = 0;
    int   load_cnt = 0;
    int   dual_ack = 0;
    logic exp_ptr  = 1'b0;

    always @(negedge clk) begin
        if (bus.mul_load) load_cnt++;
        if (bus.ack0 && bus.ack1) dual_ack++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] m;
        int k;
        if (a == 16'd0 || b == 16'd0) return 1;
        m = b;
`ifdef MUL_SCHED_SWAP_EN
        if (a < b) m = a;
`endif
        k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        return k + 3;
    endfunction

    function automatic exp_t mk(input logic id, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.id   = id;
        e.prod = 32'(a) * 32'(b);
        e.lat  = exp_lat(a, b);
        return e;
    endfunction

    // Waits up to 60 cycles for an ack; drops the acked client's request
    task automatic wait_ack(output logic id, output logic [31:0] res, output int lat, output bit to);
        id = 1'b0; res = '0; lat = -1; to = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                id  = bus.ack1;
                res = bus.result;
                lat = i;
                to  = 1'b0;
                if (bus.ack1) bus.req1 = 1'b0;
                else          bus.req0 = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic id; logic [31:0] r; int lat; bit to; exp_t e;
        @(negedge clk);
        reset = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 16'd3; bus.b0 = 16'd5;
        repeat (2) @(negedge clk);
        checks++; if (bus.ack0 !== 1'b0) $display("FAIL rst_ack0 got %b exp 0", bus.ack0); else passes++;
        checks++; if (bus.ack1 !== 1'b0) $display("FAIL rst_ack1 got %b exp 0", bus.ack1); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else passes++;
        checks++; if (bus.mul_load !== 1'b0) $display("FAIL rst_load got %b exp 0", bus.mul_load); else passes++;
        checks++; if (bus.result !== 32'd0) $display("FAIL rst_result got %h exp 0", bus.result); else passes++;
        checks++; if (bus.mul_a !== 16'd0 || bus.mul_b !== 16'd0)
            $display("FAIL rst_mul_ops got %h/%h exp 0/0", bus.mul_a, bus.mul_b); else passes++;
        sb.push_back(mk(1'b0, 16'd3, 16'd5));
        exp_ptr = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) $display("FAIL rst_release_grant busy got %b exp 1", bus.busy); else passes++;
        wait_ack(id, r, lat, to);
        e = sb.pop_front();
        checks++; if (to || id !== e.id) $display("FAIL rst_first_id got %b exp %b (timeout %0d)", id, e.id, to); else passes++;
        checks++; if (r !== e.prod) $display("FAIL rst_first_result got %h exp %h", r, e.prod); else passes++;
        checks++; if (lat + 1 !== e.lat) $display("FAIL rst_first_latency got %0d exp %0d", lat + 1, e.lat); else passes++;
    endtask

    task automatic test_single(input logic [15:0] a, input logic [15:0] b);
        logic id; logic [31:0] r; int lat; bit to; exp_t e; int l0;
        @(negedge clk);
        l0 = load_cnt;
        bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
        sb.push_back(mk(1'b0, a, b));
        exp_ptr = 1'b1;
        wait_ack(id, r, lat, to);
        e = sb.pop_front();
        checks++; if (to || id !== e.id) $display("FAIL single_id got %b exp %b (timeout %0d)", id, e.id, to); else passes++;
        checks++; if (r !== e.prod) $display("FAIL single_result got %h exp %h", r, e.prod); else passes++;
        checks++; if (lat !== e.lat) $display("FAIL single_latency got %0d exp %0d", lat, e.lat); else passes++;
        checks++; if (load_cnt - l0 !== 1) $display("FAIL single_load_pulses got %0d exp 1", load_cnt - l0); else passes++;
    endtask

    task automatic test_zero();
        logic id; logic [31:0] r; int lat; bit to; exp_t e; int l0;
        @(negedge clk);
        l0 = load_cnt;
        bus.a1 = 16'h1234; bus.b1 = 16'h0000; bus.req1 = 1'b1;
        sb.push_back(mk(1'b1, 16'h1234, 16'h0000));
        exp_ptr = 1'b0;
        wait_ack(id, r, lat, to);
        e = sb.pop_front();
        checks++; if (to || id !== e.id) $display("FAIL zero_id got %b exp %b (timeout %0d)", id, e.id, to); else passes++;
        checks++; if (r !== e.prod) $display("FAIL zero_result got %h exp %h", r, e.prod); else passes++;
        checks++; if (lat !== e.lat) $display("FAIL zero_latency got %0d exp %0d", lat, e.lat); else passes++;
        checks++; if (load_cnt !== l0) $display("FAIL zero_load_pulses got %0d exp 0", load_cnt - l0); else passes++;
    endtask

    task automatic test_contention(input int round);
        logic id; logic [31:0] r; int lat; bit to; exp_t e;
        logic [15:0] ca0, cb0, ca1, cb1;
        logic first;
        if (round == 0) begin
            ca0 = 16'd7; cb0 = 16'd2; ca1 = 16'hFFFF; cb1 = 16'hFFFF;
        end else begin
            ca0 = 16'h1234; cb0 = 16'h0010; ca1 = 16'h0005; cb1 = 16'h0300;
        end
        @(negedge clk);
        first = exp_ptr;
        if (first == 1'b0) begin
            sb.push_back(mk(1'b0, ca0, cb0)); sb.push_back(mk(1'b1, ca1, cb1));
        end else begin
            sb.push_back(mk(1'b1, ca1, cb1)); sb.push_back(mk(1'b0, ca0, cb0));
        end
        exp_ptr = first;
        bus.a0 = ca0; bus.b0 = cb0; bus.a1 = ca1; bus.b1 = cb1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_ack(id, r, lat, to);
            e = sb.pop_front();
            checks++; if (to || id !== e.id)
                $display("FAIL contention%0d_id%0d got %b exp %b (timeout %0d)", round, n, id, e.id, to); else passes++;
            checks++; if (r !== e.prod)
                $display("FAIL contention%0d_result%0d got %h exp %h", round, n, r, e.prod); else passes++;
            // second grant happens in the IDLE cycle after the first DONE
            checks++; if (lat !== e.lat + n)
                $display("FAIL contention%0d_latency%0d got %0d exp %0d", round, n, lat, e.lat + n); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        acks = 0;
        @(negedge clk);
        bus.a0 = 16'd9; bus.b0 = 16'h8000; bus.req0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack0 || bus.ack1) acks++;
        end
        checks++; if (bus.busy !== 1'b1) $display("FAIL midrst_busy_before got %b exp 1", bus.busy); else passes++;
        reset = 1'b1;
        bus.req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", bus.busy); else passes++;
        checks++; if (bus.result !== 32'd0) $display("FAIL midrst_result got %h exp 0", bus.result); else passes++;
        checks++; if (bus.mul_a !== 16'd0) $display("FAIL midrst_mul_a got %h exp 0", bus.mul_a); else passes++;
        reset = 1'b0;
        exp_ptr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack0 || bus.ack1 || bus.busy) acks++;
        end
        checks++; if (acks !== 0) $display("FAIL midrst_no_ack got %0d events exp 0", acks); else passes++;
    endtask

    task automatic test_violation();
        logic id; logic [31:0] r; int lat; bit to;
        @(negedge clk);
        viol = 1'b1;
        bus.a0 = 16'd3; bus.b0 = 16'd5; bus.req0 = 1'b1;
        exp_ptr = 1'b1;
        wait_ack(id, r, lat, to);
        viol = 1'b0;
        checks++; if (to || id !== 1'b0) $display("FAIL viol_id got %b exp 0 (timeout %0d)", id, to); else passes++;
        checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL viol_result got %h exp ffffffff", r); else passes++;
        checks++; if (lat !== 3) $display("FAIL viol_latency got %0d exp 3", lat); else passes++;
    endtask

    initial begin
        reset = 1'b1; viol = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        test_reset();
        test_zero();
        test_contention(0);
        test_single(16'd3, 16'd5);
        test_contention(1);
        test_single(16'h0002, 16'h8000);
        test_reset_mid();
        test_violation();
        checks++; if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d exp 0", sb.size()); else passes++;
        checks++; if (dual_ack !== 0) $display("FAIL dual_ack got %0d exp 0", dual_ack); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
